// File: rtl/sonata_in_pin_conditioner_pkg.sv
// Shared constants and helpers for the input-pin conditioner.
package sonata_in_pin_conditioner_pkg;

  localparam int unsigned IN_PIN_NUM = 8;

  typedef logic [IN_PIN_NUM-1:0] sonata_in_pins_t;

  // Counter width that can hold any value 0..cycles.
  function automatic int unsigned dbnc_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sonata_in_pin_conditioner_pin_debounce.sv
// Single-pin conditioner: 2-flop synchroniser, debounce counter, level,
// rise/fall pulses and sticky change flag.
module pin_debounce
  import sonata_in_pin_conditioner_pkg::*;
#(
  parameter int unsigned DebounceCycles = 16,
  parameter logic        ResetValue     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  input  logic debounce_en_i,
  input  logic evt_clr_i,
  output logic pin_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_o
);

  localparam int unsigned   CntW    = dbnc_cnt_width(DebounceCycles);
  localparam logic [CntW:0] ThrDbnc = (CntW+1)'(DebounceCycles);
  localparam logic [CntW:0] ThrByp  = (CntW+1)'(1);

  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;

  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            evt_q, evt_d;
  logic [CntW:0]   thr, cnt_inc;

  always_comb begin
    thr      = debounce_en_i ? ThrDbnc : ThrByp;
    cnt_inc  = {1'b0, cnt_q} + (CntW+1)'(1);
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    evt_d    = evt_q & ~evt_clr_i;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_inc >= thr) begin
      // >= so a threshold lowered mid-count still accepts on the next edge
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
      evt_d    = 1'b1;
    end else begin
      cnt_d = cnt_inc[CntW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= ResetValue;
      sync2_q  <= ResetValue;
      stable_q <= ResetValue;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      evt_q    <= evt_d;
    end
  end

  assign pin_o  = stable_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign evt_o  = evt_q;

endmodule

// File: rtl/sonata_in_pin_conditioner.sv
// Conditions the board's dedicated input pins: one independent debouncer per pin.
module sonata_in_pin_conditioner
  import sonata_in_pin_conditioner_pkg::*;
#(
  parameter int unsigned          NumPins        = IN_PIN_NUM,
  parameter int unsigned          DebounceCycles = 16,
  parameter logic [NumPins-1:0]   ResetValue     = '1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumPins-1:0] pins_i,
  input  logic [NumPins-1:0] debounce_en_i,
  input  logic [NumPins-1:0] evt_clr_i,
  output logic [NumPins-1:0] pins_o,
  output logic [NumPins-1:0] rise_o,
  output logic [NumPins-1:0] fall_o,
  output logic [NumPins-1:0] evt_o
);

  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    pin_debounce #(
      .DebounceCycles(DebounceCycles),
      .ResetValue    (ResetValue[i])
    ) u_pin (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pin_i        (pins_i[i]),
      .debounce_en_i(debounce_en_i[i]),
      .evt_clr_i    (evt_clr_i[i]),
      .pin_o        (pins_o[i]),
      .rise_o       (rise_o[i]),
      .fall_o       (fall_o[i]),
      .evt_o        (evt_o[i])
    );
  end

endmodule
